axis_governor_ctrl: RTL and testbench

- Sequencing controller for one AXI Stream governor instance.
- Accepts debug commands: pause, free-run, single-step N flits, run-to-TLAST, run-to-watchpoint, set drop, set log.
- Drives the governor's pause/drop/log_en controls from flops.
- Counts accepted input flits by snooping the governor's input-side handshake. Sits between the debug command channel and the governor.

---
 rtl/axis_governor_ctrl.sv | 151 +++++++++++++++
 tb/tb_axis_governor_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_governor_ctrl.sv
// Debug sequencer for one AXI Stream governor: pause / run / step-N / run-until, plus drop and log_en control.
// Latency: commands and terminating flits take effect on the next clock edge; pause/drop/log_en come straight from flops.
// Backpressure: the command channel is never stalled (cmd_ready = 1 out of reset); the flit stream is only snooped.
module axis_governor_ctrl #(
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter bit          RESET_PAUSED = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [CNT_WIDTH-1:0]  cmd_arg,
    input  logic [DATA_WIDTH-1:0] mon_TDATA,
    input  logic                  mon_TLAST,
    input  logic                  mon_TVALID,
    input  logic                  mon_TREADY,
    input  logic [DATA_WIDTH-1:0] wp_value,
    input  logic [DATA_WIDTH-1:0] wp_mask,
    output logic                  pause,
    output logic                  drop,
    output logic                  log_en,
    output logic [1:0]            state,
    output logic [CNT_WIDTH-1:0]  flit_cnt,
    output logic                  done
);

    localparam logic [1:0] ST_PAUSED   = 2'd0;
    localparam logic [1:0] ST_RUNNING  = 2'd1;
    localparam logic [1:0] ST_STEPPING = 2'd2;
    localparam logic [1:0] ST_UNTIL    = 2'd3;
    localparam logic [1:0] ST_RESET    = RESET_PAUSED ? ST_PAUSED : ST_RUNNING;

    localparam logic [2:0] OP_PAUSE    = 3'd1;
    localparam logic [2:0] OP_RUN      = 3'd2;
    localparam logic [2:0] OP_STEP     = 3'd3;
    localparam logic [2:0] OP_RUN_LAST = 3'd4;
    localparam logic [2:0] OP_RUN_WP   = 3'd5;
    localparam logic [2:0] OP_SET_DROP = 3'd6;
    localparam logic [2:0] OP_SET_LOG  = 3'd7;

    // until_kind encoding: 0 = stop on TLAST, 1 = stop on watchpoint hit
    localparam logic KIND_LAST  = 1'b0;
    localparam logic KIND_WATCH = 1'b1;

    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
    logic                 until_kind_q, until_kind_d;
    logic                 drop_q, drop_d;
    logic                 log_en_q, log_en_d;
    logic                 done_q, done_d;
    logic [CNT_WIDTH-1:0] flit_cnt_q, flit_cnt_d;
    logic                 cmd_ready_q;

    logic xfer;
    logic cmd;
    logic wp_hit;
    logic term;

    assign xfer   = mon_TVALID & mon_TREADY;
    assign cmd    = cmd_valid & cmd_ready_q;
    assign wp_hit = (((mon_TDATA ^ wp_value) & wp_mask) == '0);

    // A terminating xfer ends STEP/UNTIL by its own condition; the flit itself still passes
    assign term = xfer &
                  (((state_q == ST_STEPPING) && (remaining_q == CNT_WIDTH'(1))) ||
                   ((state_q == ST_UNTIL) &&
                    ((until_kind_q == KIND_LAST) ? mon_TLAST : wp_hit)));

    // State and control register bank, all cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RESET;
            remaining_q  <= '0;
            until_kind_q <= KIND_LAST;
            drop_q       <= 1'b0;
            log_en_q     <= 1'b0;
            done_q       <= 1'b0;
            flit_cnt_q   <= '0;
            cmd_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            until_kind_q <= until_kind_d;
            drop_q       <= drop_d;
            log_en_q     <= log_en_d;
            done_q       <= done_d;
            flit_cnt_q   <= flit_cnt_d;
            cmd_ready_q  <= 1'b1;
        end
    end

    // Next state: snooped traffic first, then an accepted command overrides the state choice
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        until_kind_d = until_kind_q;
        drop_d       = drop_q;
        log_en_d     = log_en_q;
        done_d       = 1'b0;
        flit_cnt_d   = flit_cnt_q + {{(CNT_WIDTH-1){1'b0}}, xfer};

        if (xfer && (state_q == ST_STEPPING)) begin
            remaining_d = remaining_q - CNT_WIDTH'(1);
        end
        if (term) begin
            state_d = ST_PAUSED;
            done_d  = 1'b1;
        end

        if (cmd) begin
            case (cmd_op)
                OP_PAUSE:    state_d = ST_PAUSED;
                OP_RUN:      state_d = ST_RUNNING;
                OP_STEP: begin
                    if (cmd_arg == '0) begin
                        state_d = ST_PAUSED;
                        done_d  = 1'b1;
                    end else begin
                        remaining_d = cmd_arg;
                        state_d     = ST_STEPPING;
                    end
                end
                OP_RUN_LAST: begin
                    until_kind_d = KIND_LAST;
                    state_d      = ST_UNTIL;
                end
                OP_RUN_WP: begin
                    until_kind_d = KIND_WATCH;
                    state_d      = ST_UNTIL;
                end
                OP_SET_DROP: drop_d   = cmd_arg[0];
                OP_SET_LOG:  log_en_d = cmd_arg[0];
                default:     ;
            endcase
        end
    end

    // Outputs are pure decodes of flops so nothing combinational reaches the governor controls
    always_comb begin
        pause     = (state_q == ST_PAUSED);
        drop      = drop_q;
        log_en    = log_en_q;
        state     = state_q;
        flit_cnt  = flit_cnt_q;
        done      = done_q;
        cmd_ready = cmd_ready_q;
    end

endmodule

// File: tb/tb_axis_governor_ctrl.sv
// Bench for axis_governor_ctrl with the governor modelled as in_rdy = ~pause.
// Table vectors check per-cycle outputs; a flit scoreboard checks exactly which flits pass.
// Every wait is bounded by a fixed cycle count plus a global watchdog.
module tb_axis_governor_ctrl;

    localparam int DW = 64;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [CW-1:0] cmd_arg;
    logic [DW-1:0] mon_TDATA;
    logic          mon_TLAST;
    logic          mon_TVALID;
    logic          mon_TREADY;
    logic [DW-1:0] wp_value;
    logic [DW-1:0] wp_mask;
    logic          pause;
    logic          drop;
    logic          log_en;
    logic [1:0]    state;
    logic [CW-1:0] flit_cnt;
    logic          done;

    always #5 clk = ~clk;

    // Governor stand-in: input side is ready exactly when not paused
    assign mon_TREADY = ~pause;

    axis_governor_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .RESET_PAUSED(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .mon_TDATA(mon_TDATA), .mon_TLAST(mon_TLAST), .mon_TVALID(mon_TVALID), .mon_TREADY(mon_TREADY),
        .wp_value(wp_value), .wp_mask(wp_mask),
        .pause(pause), .drop(drop), .log_en(log_en), .state(state), .flit_cnt(flit_cnt), .done(done)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } flit_t;

    typedef struct {
        logic          cv;
        logic [2:0]    op;
        logic [CW-1:0] arg;
        logic          tv;
        logic [1:0]    st;
        logic          ps;
        logic          dr;
        logic          lg;
        logic          dn;
        logic [CW-1:0] cnt;
    } vec_t;

    flit_t         src_q[$];
    logic [DW-1:0] exp_q[$];
    vec_t          vq[$];
    vec_t          tbl[15];
    vec_t          cur;
    logic [DW-1:0] exp_front;
    int            n_chk = 0;
    int            n_fail = 0;
    int            done_seen;
    bit            sb_en = 1'b0;
    bit            src_hold = 1'b0;
    logic [CW-1:0] base;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Flit scoreboard: every accepted flit must match the next expected one
    always @(posedge clk) begin
        if (rst_n && sb_en && mon_TVALID && mon_TREADY) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_flit: got %0h, expected none", mon_TDATA);
            end else begin
                exp_front = exp_q.pop_front();
                chk("flit_data", mon_TDATA, exp_front);
            end
        end
    end

    // One clock of stimulus: optional command plus head-of-queue flit; called at posedge+1
    task automatic step(input logic cv, input logic [2:0] op, input logic [CW-1:0] arg);
        bit acc;
        cmd_valid = cv;
        cmd_op    = op;
        cmd_arg   = arg;
        if (src_q.size() > 0 && !src_hold) begin
            mon_TVALID = 1'b1;
            mon_TDATA  = src_q[0].data;
            mon_TLAST  = src_q[0].last;
        end else begin
            mon_TVALID = 1'b0;
            mon_TDATA  = '0;
            mon_TLAST  = 1'b0;
        end
        #1;
        acc = mon_TVALID & mon_TREADY;
        @(posedge clk);
        #1;
        if (acc) void'(src_q.pop_front());
        if (done) done_seen++;
        cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 3'd0, '0);
    endtask

    task automatic load(input logic [DW-1:0] d, input logic l, input bit expect_it);
        flit_t f;
        f.data = d;
        f.last = l;
        src_q.push_back(f);
        if (expect_it) exp_q.push_back(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // cv op arg tv | state pause drop log done cnt
        tbl[0]  = '{1'b1, 3'd0, 16'd0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
        tbl[1]  = '{1'b1, 3'd7, 16'd1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2};
        tbl[2]  = '{1'b1, 3'd6, 16'd1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd3};
        tbl[3]  = '{1'b1, 3'd1, 16'd0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd4};
        tbl[4]  = '{1'b0, 3'd0, 16'd0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd4};
        tbl[5]  = '{1'b1, 3'd3, 16'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd4};
        tbl[6]  = '{1'b0, 3'd0, 16'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd4};
        tbl[7]  = '{1'b1, 3'd6, 16'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd4};
        tbl[8]  = '{1'b1, 3'd3, 16'd2, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 16'd4};
        tbl[9]  = '{1'b0, 3'd0, 16'd0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 16'd5};
        tbl[10] = '{1'b0, 3'd0, 16'd0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 16'd5};
        tbl[11] = '{1'b0, 3'd0, 16'd0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd6};
        tbl[12] = '{1'b0, 3'd0, 16'd0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd6};
        tbl[13] = '{1'b1, 3'd7, 16'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd6};
        tbl[14] = '{1'b1, 3'd2, 16'd0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd6};

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0;
        mon_TVALID = 1'b0; mon_TLAST = 1'b0; mon_TDATA = '0;
        wp_value = '0; wp_mask = '0;
        done_seen = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 64'(state), 64'd1);
        chk("rst_pause", 64'(pause), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_cnt", 64'(flit_cnt), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("cmd_ready_up", 64'(cmd_ready), 64'd1);

        // Continuous traffic in RUNNING, drop/log set on the way
        sb_en = 1'b1;
        for (int k = 0; k < 12; k++) load(64'h100 + 64'(k), 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) step(k < 2, (k == 0) ? 3'd6 : 3'd7, 16'd1);
        chk("run_cnt10", 64'(flit_cnt), 64'd10);
        chk("run_drop", 64'(drop), 64'd1);
        chk("run_log", 64'(log_en), 64'd1);
        idle(2);
        chk("run_cnt12", 64'(flit_cnt), 64'd12);

        // Reset asserted mid-stream clears everything immediately
        load(64'h1FF, 1'b0, 1'b0);
        mon_TVALID = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("arst_cnt", 64'(flit_cnt), 64'd0);
        chk("arst_state", 64'(state), 64'd1);
        chk("arst_drop", 64'(drop), 64'd0);
        chk("arst_log", 64'(log_en), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        sb_en = 1'b0;
        src_q.delete();
        exp_q.delete();
        mon_TVALID = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven per-cycle vectors
        for (int i = 0; i < 15; i++) begin
            cmd_valid  = tbl[i].cv;
            cmd_op     = tbl[i].op;
            cmd_arg    = tbl[i].arg;
            mon_TVALID = tbl[i].tv;
            mon_TDATA  = 64'(i);
            mon_TLAST  = 1'b0;
            vq.push_back(tbl[i]);
            @(posedge clk);
            #1;
            cur = vq.pop_front();
            chk($sformatf("v%0d_state", i), 64'(state), 64'(cur.st));
            chk($sformatf("v%0d_pause", i), 64'(pause), 64'(cur.ps));
            chk($sformatf("v%0d_drop", i), 64'(drop), 64'(cur.dr));
            chk($sformatf("v%0d_log", i), 64'(log_en), 64'(cur.lg));
            chk($sformatf("v%0d_done", i), 64'(done), 64'(cur.dn));
            chk($sformatf("v%0d_cnt", i), 64'(flit_cnt), 64'(cur.cnt));
        end
        cmd_valid = 1'b0;
        mon_TVALID = 1'b0;
        sb_en = 1'b1;

        // PAUSE then STEP 3: exactly three flits pass
        step(1'b1, 3'd1, '0);
        base = flit_cnt;
        for (int k = 0; k < 8; k++) load(64'hA00 + 64'(k), 1'b0, k < 3);
        done_seen = 0;
        step(1'b1, 3'd3, 16'd3);
        idle(8);
        chk("step3_cnt", 64'(flit_cnt), 64'(base + 16'd3));
        chk("step3_done", 64'(done_seen), 64'd1);
        chk("step3_state", 64'(state), 64'd0);
        chk("step3_exp_left", 64'(exp_q.size()), 64'd0);
        src_q.delete();

        // STEP 0: no flit, single done pulse
        base = flit_cnt;
        load(64'hB00, 1'b0, 1'b0);
        done_seen = 0;
        step(1'b1, 3'd3, 16'd0);
        idle(3);
        chk("step0_done", 64'(done_seen), 64'd1);
        chk("step0_state", 64'(state), 64'd0);
        chk("step0_cnt", 64'(flit_cnt), 64'(base));
        src_q.delete();

        // RUN_TO_LAST on a 5-flit packet; next packet held off
        base = flit_cnt;
        for (int k = 1; k <= 5; k++) load(64'hC0 + 64'(k), k == 5, 1'b1);
        load(64'hD1, 1'b0, 1'b0);
        done_seen = 0;
        step(1'b1, 3'd4, '0);
        idle(10);
        chk("last_cnt", 64'(flit_cnt), 64'(base + 16'd5));
        chk("last_done", 64'(done_seen), 64'd1);
        chk("last_state", 64'(state), 64'd0);
        chk("last_next_held", 64'(src_q.size()), 64'd1);
        src_q.delete();

        // RUN_TO_WATCH stops on the first masked match
        wp_value = 64'h00AB;
        wp_mask  = 64'h00FF;
        base = flit_cnt;
        load(64'h1100, 1'b0, 1'b1);
        load(64'h22AB, 1'b0, 1'b1);
        load(64'h33AB, 1'b0, 1'b0);
        done_seen = 0;
        step(1'b1, 3'd5, '0);
        idle(6);
        chk("wp_cnt", 64'(flit_cnt), 64'(base + 16'd2));
        chk("wp_done", 64'(done_seen), 64'd1);
        chk("wp_state", 64'(state), 64'd0);
        chk("wp_left", 64'(src_q.size()), 64'd1);
        src_q.delete();

        // STEP 5 preempted by PAUSE after two flits: no done
        base = flit_cnt;
        for (int k = 0; k < 10; k++) load(64'hE00 + 64'(k), 1'b0, k < 2);
        done_seen = 0;
        step(1'b1, 3'd3, 16'd5);
        idle(2);
        src_hold = 1'b1;
        step(1'b1, 3'd1, '0);
        src_hold = 1'b0;
        idle(3);
        chk("pre_state", 64'(state), 64'd0);
        chk("pre_done", 64'(done_seen), 64'd0);
        chk("pre_cnt", 64'(flit_cnt), 64'(base + 16'd2));
        chk("pre_exp_left", 64'(exp_q.size()), 64'd0);
        src_q.delete();

        // SET_DROP together with the terminating flit of STEP 1
        base = flit_cnt;
        for (int k = 0; k < 3; k++) load(64'hF00 + 64'(k), 1'b0, k < 1);
        step(1'b1, 3'd3, 16'd1);
        step(1'b1, 3'd6, 16'd1);
        chk("sim_drop", 64'(drop), 64'd1);
        chk("sim_state", 64'(state), 64'd0);
        chk("sim_done", 64'(done), 64'd1);
        idle(3);
        chk("sim_cnt", 64'(flit_cnt), 64'(base + 16'd1));
        chk("sim_exp_left", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
